// File: rtl/serial_word_deser_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_word_deser_pkg : state encodings shared with the other serial stages
// Rev 1.0
// ---------------------------------------------------------------------------
package serial_word_deser_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_PARITY  = 2'd1,
    ST_HOLD    = 2'd2
  } deser_state_e;

endpackage
`default_nettype wire

// File: rtl/serial_word_deser_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_word_deser_if : bit-stream input and word output of the deserialiser
// Rev 1.0   (parity_err present only with DESER_PARITY_EN)
// ---------------------------------------------------------------------------
interface serial_word_deser_if #(
  parameter int WIDTH = 8
) ();

  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
`ifdef DESER_PARITY_EN
  logic             parity_err;

  modport slave  (input  bit_in, bit_valid, word_ready,
                  output bit_ready, word_out, word_valid, parity_err);
  modport master (output bit_in, bit_valid, word_ready,
                  input  bit_ready, word_out, word_valid, parity_err);
`else
  modport slave  (input  bit_in, bit_valid, word_ready,
                  output bit_ready, word_out, word_valid);
  modport master (output bit_in, bit_valid, word_ready,
                  input  bit_ready, word_out, word_valid);
`endif

endinterface
`default_nettype wire

// File: rtl/serial_word_deser_bit_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_word_deser_bit_counter : modulo-WIDTH bit counter with terminal count
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_word_deser_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en_i,
  output logic      tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o  = (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_word_deser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_word_deser : collects WIDTH serial bits into a word on a valid/ready port
// Rev 1.0   (optional even-parity bit per word: DESER_PARITY_EN)
// ---------------------------------------------------------------------------
module serial_word_deser
  import serial_word_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_word_deser_if.slave bus
);

  deser_state_e     state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic [WIDTH-1:0] shifted;
  logic             bit_ready;
  logic             cnt_en;
  logic             cnt_tc;
`ifdef DESER_PARITY_EN
  logic             perr_q, perr_d;
`endif

  // MSB_FIRST shifts left so the first bit ends up in the top position.
  assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], bus.bit_in}
                             : {bus.bit_in, shift_q[WIDTH-1:1]};

  serial_word_deser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en_i (cnt_en),
    .tc_o (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    word_d    = word_q;
    cnt_en    = 1'b0;
    bit_ready = 1'b1;
`ifdef DESER_PARITY_EN
    perr_d    = perr_q;
`endif
    case (state_q)
      ST_COLLECT: begin
        if (bus.bit_valid) begin
          shift_d = shifted;
          cnt_en  = 1'b1;
          if (cnt_tc) begin
`ifdef DESER_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_HOLD;
            word_d  = shifted;
`endif
          end
        end
      end
`ifdef DESER_PARITY_EN
      ST_PARITY: begin
        if (bus.bit_valid) begin
          state_d = ST_HOLD;
          word_d  = shift_q;
          perr_d  = ^{shift_q, bus.bit_in};
        end
      end
`endif
      ST_HOLD: begin
        // A bit offered during the handshake cycle starts the next word.
        bit_ready = bus.word_ready;
        if (bus.word_ready) begin
          state_d = ST_COLLECT;
          if (bus.bit_valid) begin
            shift_d = shifted;
            cnt_en  = 1'b1;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      shift_q <= '0;
      word_q  <= '0;
`ifdef DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      word_q  <= word_d;
`ifdef DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.bit_ready  = bit_ready;
  assign bus.word_out   = word_q;
  assign bus.word_valid = (state_q == ST_HOLD);
`ifdef DESER_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule
`default_nettype wire
